// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm matrix-vector multiplier.
// Optional signed saturation is enabled with the MVM_SATURATE_EN macro.
package mvm_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   // Accumulator width: full-precision signed sum when saturating, else wrap at WIDTH.
   function automatic int unsigned acc_width(input int unsigned width, input int unsigned dim);
`ifdef MVM_SATURATE_EN
      return 2 * width + $clog2(dim);
`else
      return width + 0 * dim;
`endif
   endfunction

   // Bit offset of element idx in a packed vector of count elements, element 0 in the MSBs.
   function automatic int unsigned elem_offset(input int unsigned idx, input int unsigned count,
                                               input int unsigned width);
      return (count - 1 - idx) * width;
   endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One row's multiply-accumulate lane with synchronous clear and enable.
// With MVM_SATURATE_EN the lane is signed and its output is clamped to WIDTH bits.
module mvm_mac_lane #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_c
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] prod;

`ifdef MVM_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] full;

   // Full-precision signed product, sign-extended into the accumulator.
   always_comb begin
      full = $signed(a) * $signed(b);
      prod = ACC_W'(full);
   end

   // Clamp the accumulated sum to the signed WIDTH-bit range.
   always_comb begin
      res_c = WIDTH'(acc);
      if ($signed(acc) > SAT_MAX) begin
         res_c = WIDTH'(SAT_MAX);
      end else if ($signed(acc) < SAT_MIN) begin
         res_c = WIDTH'(SAT_MIN);
      end
   end
`else
   // Low WIDTH bits of the product; sum wraps naturally in the WIDTH-bit accumulator.
   always_comb begin
      prod  = ACC_W'(a * b);
      res_c = WIDTH'(acc);
   end
`endif

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/mvm.sv
// Sequential matrix-vector multiplier: all rows in parallel, one column per clock.
// Result appears SHARED_DIM+1 edges after start is accepted.
// Optional signed saturation is enabled with the MVM_SATURATE_EN macro.
module mvm
   import mvm_pkg::*;
#(
   parameter int unsigned MATRIX_ROWS = 3,
   parameter int unsigned SHARED_DIM  = 3,
   parameter int unsigned WIDTH       = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
   input  logic [SHARED_DIM*WIDTH-1:0]         vector,
   output logic [MATRIX_ROWS*WIDTH-1:0]        result_vector,
   output logic                                done
);

   localparam int unsigned ACC_W = acc_width(WIDTH, SHARED_DIM);
   localparam int unsigned CNT_W = $clog2(SHARED_DIM + 1);
   localparam int unsigned NELEM = MATRIX_ROWS * SHARED_DIM;

   logic [1:0]                  state;
   logic [1:0]                  state_nxt;
   logic [CNT_W-1:0]            col;
   logic [NELEM*WIDTH-1:0]      m_q;
   logic [SHARED_DIM*WIDTH-1:0] v_q;
   logic                        accept;
   logic                        last;
   logic                        mac_en;
   logic [WIDTH-1:0]            a_sel [MATRIX_ROWS];
   logic [WIDTH-1:0]            b_sel;
   logic [WIDTH-1:0]            lane_res [MATRIX_ROWS];
   logic [MATRIX_ROWS*WIDTH-1:0] res_all;

   // Control decodes.
   always_comb begin
      accept = start && ((state == ST_IDLE) || (state == ST_DONE));
      last   = (state == ST_COMPUTE) && (col == CNT_W'(SHARED_DIM));
      mac_en = (state == ST_COMPUTE) && (col < CNT_W'(SHARED_DIM));
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_nxt = ST_COMPUTE;
         ST_COMPUTE:       if (col == CNT_W'(SHARED_DIM)) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Operand latch, column counter and result/done registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q           <= '0;
         v_q           <= '0;
         col           <= '0;
         result_vector <= '0;
         done          <= 1'b0;
      end else if (accept) begin
         m_q  <= matrix;
         v_q  <= vector;
         col  <= '0;
         done <= 1'b0;
      end else if (last) begin
         result_vector <= res_all;
         done          <= 1'b1;
      end else if (mac_en) begin
         col <= col + CNT_W'(1);
      end
   end

   // Select the current column's matrix elements and vector element.
   always_comb begin
      b_sel = '0;
      for (int r = 0; r < MATRIX_ROWS; r++) begin
         a_sel[r] = '0;
      end
      for (int c = 0; c < SHARED_DIM; c++) begin
         if (col == CNT_W'(c)) begin
            b_sel = v_q[elem_offset(c, SHARED_DIM, WIDTH) +: WIDTH];
            for (int r = 0; r < MATRIX_ROWS; r++) begin
               a_sel[r] = m_q[elem_offset(r * SHARED_DIM + c, NELEM, WIDTH) +: WIDTH];
            end
         end
      end
   end

   // Pack lane outputs, row 0 in the MSBs.
   always_comb begin
      res_all = '0;
      for (int r = 0; r < MATRIX_ROWS; r++) begin
         res_all[elem_offset(r, MATRIX_ROWS, WIDTH) +: WIDTH] = lane_res[r];
      end
   end

   for (genvar r = 0; r < MATRIX_ROWS; r++) begin : g_lane
      mvm_mac_lane #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (reset),
         .clr   (accept),
         .en    (mac_en),
         .a     (a_sel[r]),
         .b     (b_sel),
         .res_c (lane_res[r])
      );
   end

endmodule

// File: tb/tb_mvm.sv
// Self-checking bench for mvm: a 3x3x8 and a 2x4x8 instance against a behavioural model.
module tb_mvm;

   logic        clk;
   logic        reset;
   logic        start3;
   logic        start24;
   logic [71:0] m3;
   logic [23:0] v3;
   logic [23:0] r3;
   logic        done3;
   logic [63:0] m24;
   logic [31:0] v24;
   logic [15:0] r24;
   logic        done24;

   int          n_vec;
   int          n_err;
   logic [23:0] prev3;
   logic [15:0] prev24;

   mvm #(.MATRIX_ROWS(3), .SHARED_DIM(3), .WIDTH(8)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3), .matrix(m3), .vector(v3),
      .result_vector(r3), .done(done3));

   mvm #(.MATRIX_ROWS(2), .SHARED_DIM(4), .WIDTH(8)) u_dut24 (
      .clk(clk), .reset(reset), .start(start24), .matrix(m24), .vector(v24),
      .result_vector(r24), .done(done24));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: dot product per row with plain integer arithmetic.
   function automatic logic [63:0] mvm_ref(input logic [255:0] m, input logic [63:0] v,
                                           input int rows, input int dim);
      logic [63:0] res;
      longint      sum, a, b;
      logic [7:0]  ea, eb;
      res = '0;
      for (int r = 0; r < rows; r++) begin
         sum = 0;
         for (int c = 0; c < dim; c++) begin
            ea = 8'(m >> ((rows * dim - 1 - (r * dim + c)) * 8));
            eb = 8'(v >> ((dim - 1 - c) * 8));
`ifdef MVM_SATURATE_EN
            a = longint'($signed(ea));
            b = longint'($signed(eb));
`else
            a = longint'(ea);
            b = longint'(eb);
`endif
            sum += a * b;
         end
`ifdef MVM_SATURATE_EN
         if (sum > 127)  sum = 127;
         if (sum < -128) sum = -128;
`endif
         res = (res << 8) | 64'(sum & 255);
      end
      return res;
   endfunction

   // One 3x3 operation; optionally scramble inputs after accept and poke start mid-compute.
   task automatic run3(input logic [71:0] m, input logic [23:0] v, input bit scramble, input bit poke);
      logic [23:0] exp;
      exp = 24'(mvm_ref(256'(m), 64'(v), 3, 3));
      @(negedge clk);
      m3 = m; v3 = v; start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      chk("accept_done_low3", 64'(done3), 64'd0);
      chk("hold_prev3", 64'(r3), 64'(prev3));
      if (scramble) begin
         m3 = {8'($urandom), 32'($urandom), 32'($urandom)};
         v3 = 24'($urandom);
      end
      for (int k = 1; k <= 4; k++) begin
         if (poke && k == 2) start3 = 1'b1;
         @(posedge clk); #1;
         start3 = 1'b0;
         if (k < 4) chk("done_early3", 64'(done3), 64'd0);
      end
      chk("done3", 64'(done3), 64'd1);
      chk("result3", 64'(r3), 64'(exp));
      prev3 = exp;
      @(posedge clk); #1;
      chk("hold_done3", 64'(done3), 64'd1);
      chk("hold_result3", 64'(r3), 64'(exp));
   endtask

   // One 2x4 operation; done is due five edges after accept.
   task automatic run24(input logic [63:0] m, input logic [31:0] v);
      logic [15:0] exp;
      exp = 16'(mvm_ref(256'(m), 64'(v), 2, 4));
      @(negedge clk);
      m24 = m; v24 = v; start24 = 1'b1;
      @(posedge clk); #1;
      start24 = 1'b0;
      chk("accept_done_low24", 64'(done24), 64'd0);
      chk("hold_prev24", 64'(r24), 64'(prev24));
      m24 = {32'($urandom), 32'($urandom)};
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         if (k < 5) chk("done_early24", 64'(done24), 64'd0);
      end
      chk("done24", 64'(done24), 64'd1);
      chk("result24", 64'(r24), 64'(exp));
      prev24 = exp;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      prev3 = '0; prev24 = '0;
      reset = 1'b0; start3 = 1'b0; start24 = 1'b0;
      m3 = '0; v3 = '0; m24 = '0; v24 = '0;
      #12;
      chk("reset_done3", 64'(done3), 64'd0);
      chk("reset_result3", 64'(r3), 64'd0);
      chk("reset_done24", 64'(done24), 64'd0);
      chk("reset_result24", 64'(r24), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run3(72'h010203040506070809, 24'h010203, 1'b0, 1'b0);
      chk("tp1_const", 64'(r3), 64'h0E2032);
      run3(72'h0A0B0C0D0E0F101111, 24'h040506, 1'b0, 1'b0);
      run3(72'h131415161718191A1B, 24'h070809, 1'b0, 1'b0);
      run3(72'h010203040506070809, 24'h010203, 1'b1, 1'b1);
      run3(72'h7F807F807F807F8080, 24'h807F80, 1'b0, 1'b0);
      run3(72'hFFFFFFFFFFFFFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);

      run24(64'h01FE03FCFC03FE01, 32'h01FE03FC);
      chk("tp5a_const", 64'(r24), 64'h1EEC);
      run24(64'h0102030405060708, 32'h01020304);
      chk("tp5b_const", 64'(r24), 64'h1E46);

      // Abort mid-compute with reset.
      @(negedge clk);
      m3 = 72'h111111111111111111; v3 = 24'h222222; start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_done", 64'(done3), 64'd0);
      chk("abort_result", 64'(r3), 64'd0);
      chk("abort_result24", 64'(r24), 64'd0);
      prev3 = '0; prev24 = '0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("abort_idle", 64'(done3), 64'd0);
      end

      for (int i = 0; i < 20; i++) begin
         run3({8'($urandom), 32'($urandom), 32'($urandom)}, 24'($urandom),
              1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 10; i++) begin
         run24({32'($urandom), 32'($urandom)}, 32'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
